fetch_controller: RTL and testbench

//  Sequences instruction fetch for the CPU: owns the fetch PC, issues

---
 rtl/fetch_controller.sv | 143 ++++++++++++++
 tb/tb_fetch_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller
//   Owns the fetch PC. It requests instruction words from instruction memory
//   over a req/ack handshake and hands each word to decode over a
//   valid/ready handshake. It also applies jump/branch redirects and handles
//   halt and resume.
//
//   Ports
//     clk, reset          rising-edge clock, async active-low reset
//     start               begin fetching (IDLE) or resume (HALTED)
//     halt_req            stop at the next instruction boundary (sticky)
//     redirect_valid/addr jump/branch target
//     imem_req/addr       memory read request, address = pc
//     imem_ack/rdata      memory read complete, read data
//     instr_valid/ready   handshake to decode
//     instr_out/pc        delivered word and the address it came from
//     pc                  current fetch PC
//     halted              high while in HALTED
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | after reset, waiting for start
//   FETCH   | imem_req raised at pc, waiting for imem_ack
//   HOLD    | word presented to decode, waiting for instr_ready
//   HALTED  | stopped at an instruction boundary, pc retained
module fetch_controller #(
  parameter int                 ADDR_W     = 8,
  parameter int                 INSTR_W    = 16,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALTED} state_t;

  state_t             state, state_nxt;
  logic               halt_pend;
  logic               redir_pend;
  logic [ADDR_W-1:0]  redir_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  begin
        // A redirect seen now or while waiting turns the returned word into
        // a discard, so we go straight back to fetching.
        if (imem_ack) begin
          if (redirect_valid || redir_pend) state_nxt = S_FETCH;
          else                              state_nxt = S_HOLD;
        end
      end
      S_HOLD:   begin
        if (redirect_valid)   state_nxt = S_FETCH;
        else if (instr_ready) state_nxt = (halt_pend || halt_req) ? S_HALTED : S_FETCH;
      end
      S_HALTED: if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      S_FETCH:  imem_req    = 1'b1;
      S_HOLD:   instr_valid = 1'b1;
      S_HALTED: halted      = 1'b1;
      default:  ;
    endcase
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= START_ADDR;
      instr_out  <= '0;
      instr_pc   <= '0;
      redir_pend <= 1'b0;
      redir_addr <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            redir_pend <= 1'b0;
            if (redirect_valid) begin
              pc <= redirect_addr;
            end else if (redir_pend) begin
              pc <= redir_addr;
            end else begin
              instr_out <= imem_rdata;
              instr_pc  <= pc;
              pc        <= pc + ADDR_W'(1);
            end
          end else if (redirect_valid) begin
            // The outstanding request must still complete, so only
            // remember the target. A later redirect overwrites it.
            redir_pend <= 1'b1;
            redir_addr <= redirect_addr;
          end
        end
        S_HOLD: begin
          if (redirect_valid) pc <= redirect_addr;
        end
        default: ;
      endcase
    end
  end

  // The flag clears only when the controller actually enters HALTED. It
  // therefore survives a halt that coincides with a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_pend <= 1'b0;
    end else if (state != S_HALTED && state_nxt == S_HALTED) begin
      halt_pend <= 1'b0;
    end else if (halt_req && (state == S_FETCH || state == S_HOLD)) begin
      halt_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt_req, redirect_valid;
  logic [7:0]  redirect_addr;
  logic        imem_ack, instr_ready;
  logic [15:0] imem_rdata;

  logic        imem_req, instr_valid, halted;
  logic [7:0]  imem_addr, instr_pc, pc;
  logic [15:0] instr_out;

  logic        w_imem_req, w_instr_valid, w_halted;
  logic [7:0]  w_imem_addr, w_instr_pc, w_pc;
  logic [15:0] w_instr_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_controller #(.ADDR_W(8), .INSTR_W(16), .START_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .pc(pc), .halted(halted)
  );

  fetch_controller #(.ADDR_W(8), .INSTR_W(16), .START_ADDR(8'hFE)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(w_instr_valid), .instr_ready(instr_ready),
    .instr_out(w_instr_out), .instr_pc(w_instr_pc), .pc(w_pc), .halted(w_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 8'h00; imem_ack = 1'b0; instr_ready = 1'b0; imem_rdata = 16'h0;
    tick(); tick();

    // reset values
    chk("rst_req",    32'(imem_req),    32'h0);
    chk("rst_valid",  32'(instr_valid), 32'h0);
    chk("rst_pc",     32'(pc),          32'h00);
    chk("rst_out",    32'(instr_out),   32'h0);
    chk("rst_halted", 32'(halted),      32'h0);
    chk("rst_wpc",    32'(w_pc),        32'hFE);
    reset = 1'b1;
    tick();
    chk("idle_req", 32'(imem_req), 32'h0);

    // 1: basic fetch, ack after two wait cycles
    start = 1'b1; instr_ready = 1'b1;
    tick(); start = 1'b0;
    chk("t1_req_c1",  32'(imem_req),  32'h1);
    chk("t1_addr_c1", 32'(imem_addr), 32'h00);
    tick();
    chk("t1_addr_c2", 32'(imem_addr), 32'h00);
    tick();
    chk("t1_addr_c3", 32'(imem_addr), 32'h00);
    imem_ack = 1'b1; imem_rdata = 16'hA5A5;
    tick(); imem_ack = 1'b0;
    chk("t1_valid",  32'(instr_valid), 32'h1);
    chk("t1_out",    32'(instr_out),   32'hA5A5);
    chk("t1_ipc",    32'(instr_pc),    32'h00);
    chk("t1_pc",     32'(pc),          32'h01);
    chk("t1_noreq",  32'(imem_req),    32'h0);
    tick();
    chk("t1_next_req",  32'(imem_req),  32'h1);
    chk("t1_next_addr", 32'(imem_addr), 32'h01);

    // 2: backpressure
    imem_ack = 1'b1; imem_rdata = 16'h1234; instr_ready = 1'b0;
    tick(); imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", 32'(instr_valid), 32'h1);
      chk("t2_out",   32'(instr_out),   32'h1234);
      chk("t2_ipc",   32'(instr_pc),    32'h01);
      chk("t2_noreq", 32'(imem_req),    32'h0);
      tick();
    end
    instr_ready = 1'b1;
    tick(); instr_ready = 1'b0;
    chk("t2_req",   32'(imem_req),    32'h1);
    chk("t2_addr",  32'(imem_addr),   32'h02);
    chk("t2_valid_lo", 32'(instr_valid), 32'h0);

    // 3a: redirect in HOLD
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick(); imem_ack = 1'b0;
    chk("t3a_hold", 32'(instr_valid), 32'h1);
    redirect_valid = 1'b1; redirect_addr = 8'h40;
    tick(); redirect_valid = 1'b0;
    chk("t3a_valid", 32'(instr_valid), 32'h0);
    chk("t3a_addr",  32'(imem_addr),   32'h40);

    // 3b: redirect together with ack
    imem_ack = 1'b1; imem_rdata = 16'hDEAD; redirect_valid = 1'b1; redirect_addr = 8'h40;
    tick(); imem_ack = 1'b0; redirect_valid = 1'b0;
    chk("t3b_valid", 32'(instr_valid), 32'h0);
    chk("t3b_req",   32'(imem_req),    32'h1);
    chk("t3b_addr",  32'(imem_addr),   32'h40);
    imem_ack = 1'b1; imem_rdata = 16'h1111; instr_ready = 1'b1;
    tick(); imem_ack = 1'b0;
    chk("t3b_out", 32'(instr_out), 32'h1111);
    tick();
    chk("t3b_addr41", 32'(imem_addr), 32'h41);

    // 3c: redirect while waiting for ack, then overwritten
    redirect_valid = 1'b1; redirect_addr = 8'h70;
    tick();
    chk("t3c_hold1", 32'(imem_addr), 32'h41);
    redirect_addr = 8'h40;
    tick(); redirect_valid = 1'b0;
    chk("t3c_hold2", 32'(imem_addr), 32'h41);
    tick();
    chk("t3c_req", 32'(imem_req), 32'h1);
    imem_ack = 1'b1; imem_rdata = 16'h2222;
    tick(); imem_ack = 1'b0;
    chk("t3c_valid", 32'(instr_valid), 32'h0);
    chk("t3c_addr",  32'(imem_addr),   32'h40);
    imem_ack = 1'b1; imem_rdata = 16'h3333;
    tick(); imem_ack = 1'b0;
    chk("t3c_out", 32'(instr_out), 32'h3333);
    chk("t3c_ipc", 32'(instr_pc),  32'h40);
    chk("t3c_pc",  32'(pc),        32'h41);
    tick();

    // 5: halt pulsed during FETCH
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    chk("t5_fetch", 32'(imem_req), 32'h1);
    imem_ack = 1'b1; imem_rdata = 16'h4444; instr_ready = 1'b0;
    tick(); imem_ack = 1'b0;
    chk("t5_out",    32'(instr_out), 32'h4444);
    chk("t5_nohalt", 32'(halted),    32'h0);
    instr_ready = 1'b1;
    tick(); instr_ready = 1'b0;
    chk("t5_halted", 32'(halted),   32'h1);
    chk("t5_pc",     32'(pc),       32'h42);
    chk("t5_noreq",  32'(imem_req), 32'h0);
    tick();
    chk("t5_still",  32'(halted),   32'h1);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_resume", 32'(imem_addr), 32'h42);
    chk("t5_unhalt", 32'(halted),    32'h0);

    // halt and redirect together in HOLD
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick(); imem_ack = 1'b0;
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h80; instr_ready = 1'b1;
    tick(); halt_req = 1'b0; redirect_valid = 1'b0;
    chk("thr_addr",   32'(imem_addr), 32'h80);
    chk("thr_halted", 32'(halted),    32'h0);
    imem_ack = 1'b1; imem_rdata = 16'h6666;
    tick(); imem_ack = 1'b0;
    chk("thr_ipc", 32'(instr_pc), 32'h80);
    tick();
    chk("thr_halt2", 32'(halted), 32'h1);
    chk("thr_pc",    32'(pc),     32'h81);

    // 6: async reset while requesting
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t6_req_pre", 32'(imem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_req",  32'(imem_req), 32'h0);
    chk("t6_pc",   32'(pc),       32'h00);
    tick(); reset = 1'b1;
    start = 1'b1;
    tick(); start = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h7777; instr_ready = 1'b0;
    tick(); imem_ack = 1'b0;
    chk("t6_hold", 32'(instr_valid), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 32'(instr_valid), 32'h0);
    chk("t6_out",   32'(instr_out),   32'h0);
    chk("t6_ipc",   32'(instr_pc),    32'h0);
    tick(); reset = 1'b1;
    tick();
    chk("t6_idle", 32'(imem_req), 32'h0);
    chk("t6_pc2",  32'(pc),       32'h00);

    // 4: wrap on the FE instance
    chk("t4_pc0", 32'(w_pc), 32'hFE);
    start = 1'b1; instr_ready = 1'b1;
    tick(); start = 1'b0;
    chk("t4_a0", 32'(w_imem_addr), 32'hFE);
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0;
    tick();
    chk("t4_a1", 32'(w_imem_addr), 32'hFF);
    imem_ack = 1'b1;
    tick(); imem_ack = 1'b0;
    tick();
    chk("t4_a2",   32'(w_imem_addr), 32'h00);
    chk("t4_main", 32'(imem_addr),   32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
